// File: rtl/rw_unit_pkg.sv
// simplerisc_pkg: widths, register indices, FSM state and writeback-source encodings.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a. Optional write-to-read bypass in the register file is enabled by RW_BYPASS_EN.
package simplerisc_pkg;

  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;

  // Link register written by call instructions.
  localparam logic [ADDR_W-1:0] RA_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LD  = 2'd1,
    SRC_RA  = 2'd2
  } wb_src_e;

  // Everything captured on start that is needed to perform the write later.
  typedef struct packed {
    logic              we;
    wb_src_e           src;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  // Call outranks load, load outranks ALU.
  function automatic wb_src_e sel_src(input logic is_call, input logic is_ld);
    if (is_call) return SRC_RA;
    if (is_ld) return SRC_LD;
    return SRC_ALU;
  endfunction

  // Return address; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] ret_addr(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

endpackage

// File: rtl/rw_unit_if.sv
// rw_unit_if: groups the sync-controller handshake, writeback operands and read ports.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, ignored while busy. RW_BYPASS_EN affects only the RTL behind it.
interface rw_unit_if;
  import simplerisc_pkg::*;

  logic              start;
  logic              isWb;
  logic              isLd;
  logic              isCall;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] ldResult;
  logic [DATA_W-1:0] pc;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              busy;
  logic              done;

  // Controller / operand-fetch side.
  modport master (
    output start, isWb, isLd, isCall, rd, aluResult, ldResult, pc, rs1, rs2,
    input  op1, op2, busy, done
  );

  // Writeback unit side.
  modport slave (
    input  start, isWb, isLd, isCall, rd, aluResult, ldResult, pc, rs1, rs2,
    output op1, op2, busy, done
  );

endinterface

// File: rtl/rw_unit_regfile.sv
// regfile: NREGS x DATA_W register array, two combinational read ports, one write port.
// Latency: write commits on the clock edge; reads are combinational.
// Backpressure: none. With RW_BYPASS_EN a read of the register being written returns the new value.
module regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [NREGS];

  // Reset clears every register and takes priority, so a write pending on the reset edge is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports, optionally forwarding the in-flight write value.
  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
`ifdef RW_BYPASS_EN
    if (we_i && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (we_i && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
`endif
  end

endmodule

// File: rtl/rw_unit.sv
// rw_unit: register-writeback stage; latches the instruction on start, selects ALU/load/return-address value and writes it.
// Latency: start to done = 2 cycles (non-load) or 2+LD_WAIT cycles (load); done is a one-cycle pulse.
// Backpressure: start while busy is dropped (no queueing). RW_BYPASS_EN enables write-to-read forwarding in the regfile.
module rw_unit
  import simplerisc_pkg::*;
#(
  parameter int LD_WAIT = 1
) (
  input logic       clk,
  input logic       reset,
  rw_unit_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_WAIT_LD = WAIT_LD;
  localparam logic [1:0] ST_WRITE   = WRITE;
  localparam logic [1:0] ST_DONE    = DONE;

  // Counter preload: LD_WAIT cycles are spent in WAIT_LD, counting LD_WAIT-1 down to 0.
  localparam logic [1:0] WAIT_INIT = (LD_WAIT > 0) ? 2'(LD_WAIT - 1) : 2'd0;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  wb_req_t           req_q, req_d;
  logic              wr_en;
  logic [DATA_W-1:0] wr_dat;

  // Next-state logic: capture on start in IDLE, optional load wait, one write cycle, one done cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          req_d.we  = bus.isWb | bus.isCall;
          req_d.src = sel_src(bus.isCall, bus.isLd);
          req_d.dst = bus.isCall ? RA_IDX : bus.rd;
          req_d.alu = bus.aluResult;
          req_d.pc  = bus.pc;
          if (bus.isLd && (LD_WAIT > 0)) begin
            state_d = ST_WAIT_LD;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WAIT_LD: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Writeback value select; load data is taken live in the WRITE cycle, not latched on start.
  always_comb begin
    case (req_q.src)
      SRC_RA:  wr_dat = ret_addr(req_q.pc);
      SRC_LD:  wr_dat = bus.ldResult;
      default: wr_dat = req_q.alu;
    endcase
  end

  assign wr_en    = (state_q == ST_WRITE) && req_q.we;
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_DONE);

  regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk_i    (clk),
    .reset_i  (reset),
    .we_i     (wr_en),
    .waddr_i  (req_q.dst),
    .wdata_i  (wr_dat),
    .raddr1_i (bus.rs1),
    .raddr2_i (bus.rs2),
    .rdata1_o (bus.op1),
    .rdata2_o (bus.op2)
  );

endmodule
